// File: rtl/layered_objects_mux_pkg.sv
// Shared types and default colours for the layered pixel compositor.
package objects_mux_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLASH_ON  = 2'd1,
    FLASH_OFF = 2'd2
  } flash_state_t;

  localparam logic [7:0] DEF_TRANSPARENT_RGB = 8'hFF;
  localparam logic [7:0] DEF_FLASH_RGB       = 8'hE0;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_priority_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module layer_priority_enc
  import objects_mux_pkg::*;
#(
  parameter int NUM_LAYERS = 8,
  parameter int IDX_W      = cnt_w(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS-1:0] req_i,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  vld_o
);

  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    // Scan downwards so the lowest requesting index is the last to write.
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IDX_W'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layered_objects_mux.sv
// Two-stage pixel compositor with per-layer enable, colour key, frame blinking
// and a frame-alternating full-screen flash effect.
module layered_objects_mux
  import objects_mux_pkg::*;
#(
  parameter int               NUM_LAYERS      = 8,
  parameter int               RGB_W           = 8,
  parameter logic [RGB_W-1:0] TRANSPARENT_RGB = RGB_W'(DEF_TRANSPARENT_RGB),
  parameter int               BLINK_FRAMES    = 16,
  parameter int               FLASH_FRAMES    = 8,
  parameter logic [RGB_W-1:0] FLASH_RGB       = RGB_W'(DEF_FLASH_RGB),
  parameter int               IDX_W           = cnt_w(NUM_LAYERS)
) (
  input  logic                             clk,
  input  logic                             resetN,
  input  logic [NUM_LAYERS-1:0]            layerDR,
  input  logic [NUM_LAYERS-1:0][RGB_W-1:0] layerRGB,
  input  logic [NUM_LAYERS-1:0]            layerEnable,
  input  logic [NUM_LAYERS-1:0]            blinkMask,
  input  logic [RGB_W-1:0]                 backGroundRGB,
  input  logic                             startOfFrame,
  input  logic                             flashTrigger,
  output logic [RGB_W-1:0]                 RGBOut,
  output logic [IDX_W-1:0]                 topLayer,
  output logic                             topValid,
  output logic                             flashActive
);

  localparam int              BCW        = cnt_w(BLINK_FRAMES);
  localparam int              FCW        = cnt_w(FLASH_FRAMES);
  localparam logic [BCW-1:0]  BLINK_LAST = BCW'(BLINK_FRAMES - 1);
  localparam logic [FCW-1:0]  FLASH_LAST = FCW'(FLASH_FRAMES - 1);

  logic [BCW-1:0]        blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  flash_state_t          state_q, state_d;
  logic [FCW-1:0]        flash_cnt_q, flash_cnt_d;
  logic                  flash_active_q;

  logic [NUM_LAYERS-1:0] eff;
  logic [IDX_W-1:0]      win_idx;
  logic                  win_vld;
  logic [RGB_W-1:0]      sel_rgb;

  logic [RGB_W-1:0]      rgb_p1_q;
  logic [IDX_W-1:0]      idx_p1_q;
  logic                  vld_p1_q;
  logic                  flash_p1_q;
  logic [RGB_W-1:0]      rgb_p2_q;
  logic [IDX_W-1:0]      idx_p2_q;
  logic                  vld_p2_q;

  always_comb begin
    eff = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      eff[i] = layerDR[i] & layerEnable[i] & (layerRGB[i] != TRANSPARENT_RGB) &
               ~(blinkMask[i] & blink_phase_q);
    end
  end

  layer_priority_enc #(
    .NUM_LAYERS(NUM_LAYERS),
    .IDX_W     (IDX_W)
  ) u_enc (
    .req_i(eff),
    .idx_o(win_idx),
    .vld_o(win_vld)
  );

  assign sel_rgb = win_vld ? layerRGB[win_idx] : backGroundRGB;

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (startOfFrame) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BCW'(1);
      end
    end
  end

  // A trigger always (re)starts the effect and masks a coincident frame pulse.
  always_comb begin
    state_d     = state_q;
    flash_cnt_d = flash_cnt_q;
    if (flashTrigger) begin
      state_d     = FLASH_ON;
      flash_cnt_d = FLASH_LAST;
    end else if (startOfFrame) begin
      case (state_q)
        FLASH_ON:  state_d = (flash_cnt_q != '0) ? FLASH_OFF : IDLE;
        FLASH_OFF: begin
          flash_cnt_d = flash_cnt_q - FCW'(1);
          state_d     = FLASH_ON;
        end
        default:   state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      state_q        <= IDLE;
      flash_cnt_q    <= '0;
      flash_active_q <= 1'b0;
      rgb_p1_q       <= '0;
      idx_p1_q       <= '0;
      vld_p1_q       <= 1'b0;
      flash_p1_q     <= 1'b0;
      rgb_p2_q       <= '0;
      idx_p2_q       <= '0;
      vld_p2_q       <= 1'b0;
    end else begin
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      state_q        <= state_d;
      flash_cnt_q    <= flash_cnt_d;
      flash_active_q <= (state_d != IDLE);
      // Stage 1: priority winner; flash state travels with the pixel it applied to
      rgb_p1_q       <= sel_rgb;
      idx_p1_q       <= win_idx;
      vld_p1_q       <= win_vld;
      flash_p1_q     <= (state_q == FLASH_ON);
      // Stage 2: flash override
      rgb_p2_q       <= flash_p1_q ? FLASH_RGB : rgb_p1_q;
      idx_p2_q       <= idx_p1_q;
      vld_p2_q       <= vld_p1_q;
    end
  end

  assign RGBOut      = rgb_p2_q;
  assign topLayer    = idx_p2_q;
  assign topValid    = vld_p2_q;
  assign flashActive = flash_active_q;

endmodule
